// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised
// synchronous write ports, optional write-to-read bypass and a post-reset init sweep.
module reg_file_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       busy,
  output logic                       wr_conflict,
  output logic                       zero_wr_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic run;
  logic zero_hit0;
  logic zero_hit1;
  logic wr0_ok;
  logic wr1_ok;

  function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
    if (INIT_MODE != 0) begin
      return DATA_W'(idx);
    end
    return '0;
  endfunction

  assign run       = (state == S_RUN);
  assign busy      = (state == S_INIT);
  assign zero_hit0 = (ZERO_REG != 0) && we0 && (waddr0 == '0);
  assign zero_hit1 = (ZERO_REG != 0) && we1 && (waddr1 == '0);
  // A write is only effective in RUN and never to the hardwired zero register.
  assign wr0_ok    = run && we0 && !zero_hit0;
  assign wr1_ok    = run && we1 && !zero_hit1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      S_INIT: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == {ADDR_W{1'b1}}) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_conflict <= 1'b0;
      zero_wr_err <= 1'b0;
    end else begin
      wr_conflict <= run && we0 && we1 && (waddr0 == waddr1);
      zero_wr_err <= run && (zero_hit0 || zero_hit1);
    end
  end

  // Storage carries no reset; the sweep gives it a defined value. Port 1 is
  // written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        mem[ptr] <= init_value(ptr);
      end else begin
        if (wr0_ok) mem[waddr0] <= wdata0;
        if (wr1_ok) mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem[ra];
      if (!run) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && wr1_ok && (waddr1 == ra)) begin
        rd = wdata1;
      end else if ((BYPASS != 0) && wr0_ok && (waddr0 == ra)) begin
        rd = wdata0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, the next generation of the single-issue MIPS register file in the datapath. Provides NUM_RD asynchronous read ports and two synchronous write ports with defined port priority. Adds optional write-to-read bypass, a hardwired zero register, and a post-reset initialisation sweep FSM. Error pulses replace simulation-only prints, so write-port conflicts and zero-register writes are visible to the pipeline control and the bench.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
INIT_MODE, 1, 0 = sweep clears every register to 0; 1 = register i initialised to value i

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (priority port)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
busy  out  1  high while the init sweep runs; writes are ignored
wr_conflict  out  1  one-cycle pulse: both ports wrote the same address
zero_wr_err  out  1  one-cycle pulse: write to register 0 dropped (ZERO_REG=1)

Behaviour:
- One clock domain: clk. Reset: rst, synchronous, active-high. No asynchronous reset.
- FSM has two states, INIT and RUN.
  - rst high at an edge: state<=INIT, ptr<=0, busy<=1, wr_conflict<=0, zero_wr_err<=0.
  - INIT: each cycle write the init value (0, or ptr per INIT_MODE) into register ptr, then ptr<=ptr+1.
  - When ptr==DEPTH-1, that register is written and state<=RUN, busy<=0 on the same edge. The sweep takes exactly DEPTH cycles after rst deasserts.
  - rst during INIT restarts the sweep at ptr=0. rst during RUN re-enters INIT. Register contents are overwritten only by the sweep.
  - Before the first rst, register and output values are undefined.
- Writes in INIT: we0 and we1 are ignored. No error pulses are raised.
- Writes in RUN are committed at the rising edge.
  - we0 and we1 both high with waddr0==waddr1: wdata1 is stored; wr_conflict=1 for the next cycle only.
  - Different addresses: both are stored.
  - Write to address 0 with ZERO_REG=1: dropped; zero_wr_err=1 for the next cycle. This also applies if both ports target 0 (wr_conflict also pulses).
- Reads are combinational from raddr with zero latency.
  - While busy=1: every rdata port returns 0.
  - ZERO_REG=1 and raddr==0: returns 0 regardless of bypass.
  - BYPASS=1 in RUN: if an enabled write port addresses raddr this cycle, return that port's wdata. Port 1 takes priority; a dropped zero-register write never forwards.
  - BYPASS=0: returns the stored (pre-edge) value.
- All read ports are independent. Any number may read the same address.
- Error outputs are registered. They are low whenever no qualifying event occurred on the previous edge.

Test Plan:
- Init sweep, INIT_MODE=1: hold rst 2 cycles, release. busy must stay 1 for exactly 32 cycles, then drop. Afterwards raddr=7 -> rdata=7 and raddr=31 -> rdata=31; raddr=0 -> 0.
- Basic write/read: in RUN, we0=1, waddr0=5, wdata0=0xDEADBEEF. Next cycle raddr port0=5 -> 0xDEADBEEF. Port1 raddr=6 -> 6, unchanged.
- Conflict: we0=we1=1, both waddr=9, wdata0=0x11, wdata1=0x22. Register 9 must read 0x22; wr_conflict high for exactly one cycle.
- Zero register: we1=1, waddr1=0, wdata1=0xFFFF. zero_wr_err pulses once and raddr=0 -> 0. With BYPASS=1 in the same cycle, raddr=0 -> 0, never forwarded.
- Bypass: BYPASS=1, we0=1, waddr0=12, wdata0=0xA5A5 with raddr port0=12 in the same cycle -> rdata=0xA5A5 before the edge. With BYPASS=0 the same stimulus -> 12 before the edge and 0xA5A5 after.
- Reset mid-sweep and busy writes: assert rst at sweep cycle 10. busy stays high for 32 cycles from the new release. we0=1, waddr0=3, wdata0=0x77 applied while busy leaves register 3 = 3 and no error pulses.
